// File: rtl/clk_div_ctrl_if.sv
// Control/status bundle for clk_div_ctrl: run request, divider load handshake
// and the divided-clock outputs.
interface clk_div_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic [WIDTH-1:0] div_val;
  logic             div_load;
  logic             div_ready;
  logic             out_clk;
  logic             tick;
  logic             busy;

  modport master (
    output en, div_val, div_load,
    input  div_ready, out_clk, tick, busy
  );

  modport slave (
    input  en, div_val, div_load,
    output div_ready, out_clk, tick, busy
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable 50% duty clock divider. A new half-period loaded while running
// is held back and applied only at a falling edge of out_clk (glitch-free).
module clk_div_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  clk_div_ctrl_if.slave   ctrl
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_hp;
  logic [WIDTH-1:0] r_pend;
  logic [WIDTH-1:0] r_cnt;
  logic             r_out_clk;
  logic             r_tick;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_hp_nxt;
  logic [WIDTH-1:0] w_pend_nxt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_out_nxt;
  logic             w_tick_nxt;
  logic             w_ready;
  logic             w_load;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_idle_hp;
  logic             w_term;
  logic             w_fall;
  logic             w_rise;

  assign w_ready = (r_state != S_PEND);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_hp      <= WIDTH'(1);
      r_pend    <= WIDTH'(1);
      r_cnt     <= '0;
      r_out_clk <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_hp      <= w_hp_nxt;
      r_pend    <= w_pend_nxt;
      r_cnt     <= w_cnt_nxt;
      r_out_clk <= w_out_nxt;
      r_tick    <= w_tick_nxt;
    end
  end

  // Next-state and datapath decode
  always_comb begin
    w_state_nxt = r_state;
    w_hp_nxt    = r_hp;
    w_pend_nxt  = r_pend;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out_clk;
    w_tick_nxt  = 1'b0;

    w_load_val = (ctrl.div_val == '0) ? WIDTH'(1) : ctrl.div_val;
    w_load     = ctrl.div_load && w_ready;
    w_term     = (r_cnt == (r_hp - WIDTH'(1)));
    w_fall     = w_term && r_out_clk;
    w_rise     = w_term && !r_out_clk;
    // hp to adopt when stopping: a held-back load wins over the active value
    w_idle_hp  = (r_state == S_PEND) ? r_pend : (w_load ? w_load_val : r_hp);

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_out_nxt = 1'b0;
        if (w_load) w_hp_nxt = w_load_val;
        if (ctrl.en) w_state_nxt = S_RUN;
      end
      default: begin
        if (!ctrl.en && (!r_out_clk || w_fall)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_out_nxt   = 1'b0;
          w_hp_nxt    = w_idle_hp;
        end else begin
          w_cnt_nxt  = w_term ? '0 : (r_cnt + WIDTH'(1));
          w_out_nxt  = w_term ? !r_out_clk : r_out_clk;
          w_tick_nxt = w_rise;
          if ((r_state == S_PEND) && w_fall) begin
            w_hp_nxt    = r_pend;
            w_state_nxt = S_RUN;
          end else if ((r_state == S_RUN) && w_load) begin
            w_pend_nxt  = w_load_val;
            w_state_nxt = S_PEND;
          end
        end
      end
    endcase
  end

  assign ctrl.div_ready = w_ready;
  assign ctrl.busy      = (r_state != S_IDLE);
  assign ctrl.out_clk   = r_out_clk;
  assign ctrl.tick      = r_tick;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: hand-computed out_clk/tick/ready/busy
// sequences for each scenario, sampled 1 time unit after the rising edge.
module tb_clk_div_ctrl;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  clk_div_ctrl_if #(.WIDTH(WIDTH)) bus ();

  clk_div_ctrl #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load a half-period while idle, then request run
  task automatic start(input logic [WIDTH-1:0] val);
    bus.div_val  = val;
    bus.div_load = 1'b1;
    step();
    bus.div_load = 1'b0;
    bus.en       = 1'b1;
  endtask

  task automatic go_idle();
    bus.en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy === 1'b0) break;
      step();
    end
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.out_clk !== 1'b0) begin
      n_err++;
      $display("FAIL go_idle busy=%b out_clk=%b required busy=0 out_clk=0", bus.busy, bus.out_clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b0; bus.div_load = 1'b0; bus.div_val = '0;
    #2 rst = 1'b0;
    #2;
    n_cmp++;
    if ({bus.out_clk, bus.tick, bus.busy, bus.div_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_async out/tick/busy/ready=%b required 0001",
               {bus.out_clk, bus.tick, bus.busy, bus.div_ready});
    end
    step(); step();
    rst = 1'b1;
    step(); step();
    n_cmp++;
    if ({bus.out_clk, bus.tick, bus.busy, bus.div_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_release out/tick/busy/ready=%b required 0001",
               {bus.out_clk, bus.tick, bus.busy, bus.div_ready});
    end
  endtask

  task automatic test_hp1();
    bus.en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      n_cmp++;
      if (bus.out_clk !== 1'(k % 2) || bus.tick !== 1'(k % 2) || bus.busy !== 1'b1) begin
        n_err++;
        $display("FAIL hp1 k=%0d out/tick/busy=%b%b%b required %b%b1",
                 k, bus.out_clk, bus.tick, bus.busy, 1'(k % 2), 1'(k % 2));
      end
    end
    go_idle();
  endtask

  task automatic test_div3();
    start(8'd3);
    for (int k = 0; k < 12; k++) begin
      step();
      n_cmp++;
      if (bus.out_clk !== 1'((k / 3) % 2) || bus.tick !== (k % 6 == 3)) begin
        n_err++;
        $display("FAIL div3 k=%0d out/tick=%b%b required %b%b",
                 k, bus.out_clk, bus.tick, 1'((k / 3) % 2), (k % 6 == 3));
      end
    end
    go_idle();
  endtask

  task automatic test_reload();
    logic [13:0] exp_out;
    exp_out = 14'b00110011110000;
    start(8'd4);
    for (int k = 0; k < 14; k++) begin
      step();
      n_cmp++;
      if (bus.out_clk !== exp_out[k] || bus.tick !== (k == 4 || k == 10) ||
          bus.div_ready !== !(k == 6 || k == 7)) begin
        n_err++;
        $display("FAIL reload k=%0d out/tick/ready=%b%b%b required %b%b%b", k,
                 bus.out_clk, bus.tick, bus.div_ready,
                 exp_out[k], (k == 4 || k == 10), !(k == 6 || k == 7));
      end
      if (k == 5) begin bus.div_val = 8'd2; bus.div_load = 1'b1; end
      if (k == 6) bus.div_load = 1'b0;
    end
    go_idle();
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_out;
    exp_out = 12'b100011001100;
    start(8'd2);
    for (int k = 0; k < 12; k++) begin
      step();
      n_cmp++;
      if (bus.out_clk !== exp_out[k] || bus.tick !== (k == 2 || k == 6 || k == 11) ||
          bus.div_ready !== !(k >= 4 && k <= 7)) begin
        n_err++;
        $display("FAIL b2b k=%0d out/tick/ready=%b%b%b required %b%b%b", k,
                 bus.out_clk, bus.tick, bus.div_ready,
                 exp_out[k], (k == 2 || k == 6 || k == 11), !(k >= 4 && k <= 7));
      end
      if (k == 3) begin bus.div_val = 8'd3; bus.div_load = 1'b1; end
      if (k == 4) bus.div_load = 1'b0;
    end
    go_idle();
  endtask

  task automatic test_stop();
    start(8'd5);
    for (int k = 0; k < 14; k++) begin
      step();
      n_cmp++;
      if (bus.out_clk !== (k >= 5 && k <= 9) || bus.busy !== (k <= 9) || bus.tick !== (k == 5)) begin
        n_err++;
        $display("FAIL stop k=%0d out/busy/tick=%b%b%b required %b%b%b", k,
                 bus.out_clk, bus.busy, bus.tick, (k >= 5 && k <= 9), (k <= 9), (k == 5));
      end
      if (k == 6) bus.en = 1'b0;
    end
  endtask

  task automatic test_zero();
    start(8'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      n_cmp++;
      if (bus.out_clk !== 1'(k % 2) || bus.tick !== 1'(k % 2)) begin
        n_err++;
        $display("FAIL zero k=%0d out/tick=%b%b required %b%b",
                 k, bus.out_clk, bus.tick, 1'(k % 2), 1'(k % 2));
      end
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    start(8'd3);
    for (int k = 0; k < 4; k++) step();
    bus.div_val  = 8'd7;
    bus.div_load = 1'b1;
    step();
    bus.div_load = 1'b0;
    n_cmp++;
    if (bus.out_clk !== 1'b1 || bus.div_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_pend out/ready=%b%b required 10", bus.out_clk, bus.div_ready);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.out_clk, bus.tick, bus.busy, bus.div_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL rmid_async out/tick/busy/ready=%b required 0001",
               {bus.out_clk, bus.tick, bus.busy, bus.div_ready});
    end
    bus.en = 1'b0;
    #2 rst = 1'b1;
    step();
    bus.en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      n_cmp++;
      if (bus.out_clk !== 1'(k % 2) || bus.tick !== 1'(k % 2)) begin
        n_err++;
        $display("FAIL rmid_hp1 k=%0d out/tick=%b%b required %b%b",
                 k, bus.out_clk, bus.tick, 1'(k % 2), 1'(k % 2));
      end
    end
    go_idle();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_hp1();
    test_div3();
    test_reload();
    test_back_to_back();
    test_stop();
    test_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, is the width of the half-period value and of the internal counter.
REQ-002 Port clk, input, 1, the single system clock; all state changes occur on its rising edge.
REQ-003 Port rst, input, 1, reset, asynchronous and active-low.
REQ-004 Port en, input, 1, run request: 1 = generate out_clk, 0 = stop at the next safe point.
REQ-005 Port div_val, input, WIDTH, requested half-period in clk cycles; 0 is treated as 1.
REQ-006 Port div_load, input, 1, request to load div_val; accepted when div_load=1 and div_ready=1 at a clk edge.
REQ-007 Port div_ready, output, 1, block can accept a new div_val this cycle.
REQ-008 Port out_clk, output, 1, registered divided clock with a 50% duty cycle and period 2*hp clk cycles.
REQ-009 Port tick, output, 1, registered one-cycle pulse, high in exactly the cycles where out_clk goes 0->1.
REQ-010 Port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-011 The block SHALL hold these registers:
- hp: active half-period, WIDTH bits
- pend: pending half-period, WIDTH bits
- cnt: counter, WIDTH bits
- state: one of IDLE, RUN, PEND
REQ-012 A terminal cycle SHALL be a cycle in RUN or PEND where cnt == hp-1. On it, out_clk toggles and cnt <= 0. In all other RUN/PEND cycles, cnt increments by 1.
REQ-013 A falling boundary SHALL be a terminal cycle with out_clk == 1. A rising boundary SHALL be a terminal cycle with out_clk == 0. tick = 1 only in the cycle after a rising boundary.
REQ-014 div_ready SHALL be 1 in IDLE and RUN, and 0 in PEND.
REQ-015 IDLE behaviour:
- out_clk = 0, cnt = 0.
- An accepted load writes max(div_val,1) to hp directly.
- When en = 1, the next state is RUN and cnt starts at 0. The first rising boundary occurs hp cycles after RUN entry.
REQ-016 RUN behaviour:
- An accepted load writes max(div_val,1) to pend and moves to PEND.
- A load accepted in the same cycle as a falling boundary is NOT applied at that boundary.
REQ-017 PEND behaviour:
- At the next falling boundary: hp <= pend, cnt <= 0, out_clk <= 0, and the next state is RUN.
- The new period starts with a full low phase of the new hp.
- out_clk SHALL never produce a phase shorter than min(old hp, new hp).
REQ-018 en = 0 in RUN or PEND:
- If out_clk == 0, go to IDLE next cycle with cnt <= 0.
- If out_clk == 1, continue until the falling boundary, then go to IDLE.
- A value held in pend SHALL be copied to hp on IDLE entry.
REQ-019 en returning to 1 before IDLE is reached SHALL cancel the stop. The stop is evaluated every cycle.
REQ-020 Arithmetic:
- hp range is 1..2^WIDTH-1. cnt never exceeds hp-1.
- hp == 1 gives out_clk = clk/2, toggling every cycle, with tick every second cycle.
REQ-021 All outputs SHALL be registered or decoded only from state, with no combinational path from inputs to out_clk or tick.

Reset
REQ-022 When rst = 0, the block SHALL asynchronously set state = IDLE, hp = 1, pend = 1, cnt = 0, out_clk = 0, tick = 0. This gives busy = 0 and div_ready = 1.
REQ-023 Reset asserted mid-operation SHALL force out_clk low immediately. Any pending load is discarded.
REQ-024 After rst deasserts, operation SHALL resume from IDLE on the first rising clk edge.

Verification
REQ-025 Reset, then en = 1 with default hp = 1 -> out_clk toggles every cycle; tick is high every 2nd cycle; busy = 1.
REQ-026 In IDLE, load div_val = 3, then en = 1 -> out_clk is 0 for 3 cycles, 1 for 3 cycles, repeating; tick once per 6 cycles.
REQ-027 Running with hp = 4, load div_val = 2 mid high phase:
- div_ready drops to 0.
- The high phase completes its full 4 cycles.
- Then low 2 / high 2 follows; div_ready returns to 1 after the boundary.
REQ-028 Running with hp = 5, deassert en in cycle 2 of the high phase -> high lasts 5 cycles, out_clk falls, busy = 0 next cycle, out_clk stays 0.
REQ-029 Load div_val = 0 in IDLE, then run -> behaves exactly as hp = 1.
REQ-030 Assert rst low while out_clk = 1 and PEND holds div_val = 7 -> out_clk = 0 immediately. After release, en = 1 runs with hp = 1, not 7.
